// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and widths for the hazard controller slice.
package pipe_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned HCNT_W    = 16;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_MWAIT,
    ST_FLUSH
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic                 load;
  } sb_rec_t;

  // A record only produces a value when it writes a real register; x0 never forwards.
  function automatic logic sb_hit(sb_rec_t rec, logic [REG_IDX_W-1:0] rs, logic use_rs);
    return use_rs && rec.valid && rec.wen && (rec.rd != '0) && (rec.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_sb.sv
// EX/MEM destination scoreboard: match decode sources against in-flight producers,
// register operand-forward selects at ID->EX transfer and flag load-use hazards.
module hazard_sb
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_wen,
  input  logic                 id_mem_reg,
  input  logic                 advance,
  input  logic                 kill,
  output logic                 load_use,
  output logic                 frwd_alu_op1,
  output logic                 frwd_mem_op1,
  output logic                 frwd_alu_op2,
  output logic                 frwd_mem_op2
);

  sb_rec_t ex_q;
  sb_rec_t mem_q;
  sb_rec_t id_rec;
  logic    ex_hit1;
  logic    ex_hit2;
  logic    mem_hit1;
  logic    mem_hit2;

  always_comb begin
    id_rec = '0;
    if (id_valid) begin
      id_rec.valid = 1'b1;
      id_rec.rd    = id_rd;
      id_rec.wen   = id_wen;
      id_rec.load  = id_mem_reg;
    end
    ex_hit1  = id_valid && sb_hit(ex_q, id_rs1, id_use_rs1);
    ex_hit2  = id_valid && sb_hit(ex_q, id_rs2, id_use_rs2);
    mem_hit1 = id_valid && sb_hit(mem_q, id_rs1, id_use_rs1);
    mem_hit2 = id_valid && sb_hit(mem_q, id_rs2, id_use_rs2);
    load_use = ex_q.load && (ex_hit1 || ex_hit2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      frwd_alu_op1 <= 1'b0;
      frwd_mem_op1 <= 1'b0;
      frwd_alu_op2 <= 1'b0;
      frwd_mem_op2 <= 1'b0;
    end else if (advance) begin
      mem_q <= ex_q;
      if (kill) begin
        ex_q         <= '0;
        frwd_alu_op1 <= 1'b0;
        frwd_mem_op1 <= 1'b0;
        frwd_alu_op2 <= 1'b0;
        frwd_mem_op2 <= 1'b0;
      end else begin
        // The younger EX producer shadows the MEM one for the same operand.
        ex_q         <= id_rec;
        frwd_alu_op1 <= ex_hit1;
        frwd_mem_op1 <= mem_hit1 && !ex_hit1;
        frwd_alu_op2 <= ex_hit2;
        frwd_mem_op2 <= mem_hit2 && !ex_hit2;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush sequencing FSM, memory-wait freeze
// and saturating hazard-cycle counter around the hazard_sb scoreboard.
module hazard_ctrl
  import pipe_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic [REG_IDX_W-1:0] i_id_rd,
  input  logic                 i_id_wen,
  input  logic                 i_id_mem_reg,
  input  logic                 i_ex_redirect,
  input  logic                 i_dmem_busy,
  output logic                 o_frwd_alu_op1,
  output logic                 o_frwd_mem_op1,
  output logic                 o_frwd_alu_op2,
  output logic                 o_frwd_mem_op2,
  output logic                 o_stall,
  output logic                 o_bubble,
  output logic                 o_flush,
  output logic [HCNT_W-1:0]    o_hazard_cnt
);

  hz_state_t          state_q, state_d;
  hz_state_t          pre_q, pre_d;
  hz_state_t          st_eval;
  logic               pend_q, pend_d;
  logic               redir;
  logic               advance;
  logic               kill;
  logic               load_use;
  logic [HCNT_W-1:0]  cnt_q;

  hazard_sb u_sb (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .id_valid     (i_id_valid),
    .id_rs1       (i_id_rs1),
    .id_rs2       (i_id_rs2),
    .id_use_rs1   (i_id_use_rs1),
    .id_use_rs2   (i_id_use_rs2),
    .id_rd        (i_id_rd),
    .id_wen       (i_id_wen),
    .id_mem_reg   (i_id_mem_reg),
    .advance      (advance),
    .kill         (kill),
    .load_use     (load_use),
    .frwd_alu_op1 (o_frwd_alu_op1),
    .frwd_mem_op1 (o_frwd_mem_op1),
    .frwd_alu_op2 (o_frwd_alu_op2),
    .frwd_mem_op2 (o_frwd_mem_op2)
  );

  // While frozen, the step of the pre-wait state is deferred; a redirect seen during
  // the wait is remembered so it still wins once the memory releases the pipe.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    pend_d  = 1'b0;
    advance = 1'b0;
    kill    = 1'b0;
    st_eval = (state_q == ST_MWAIT) ? pre_q : state_q;
    redir   = i_ex_redirect || ((state_q == ST_MWAIT) && pend_q);
    if (i_dmem_busy) begin
      state_d = ST_MWAIT;
      if (state_q != ST_MWAIT) begin
        pre_d  = state_q;
        pend_d = i_ex_redirect;
      end else begin
        pend_d = pend_q || i_ex_redirect;
      end
    end else begin
      advance = 1'b1;
      case (st_eval)
        ST_LU_STALL: begin
          state_d = redir ? ST_FLUSH : ST_RUN;
          kill    = redir;
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
          kill    = 1'b1;
        end
        default: begin
          if (redir) begin
            state_d = ST_FLUSH;
            kill    = 1'b1;
          end else if (load_use) begin
            state_d = ST_LU_STALL;
            kill    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      pre_q   <= ST_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
    end
  end

  assign o_stall      = (state_q == ST_LU_STALL) || (state_q == ST_MWAIT);
  assign o_bubble     = (state_q == ST_LU_STALL) || (state_q == ST_FLUSH);
  assign o_flush      = (state_q == ST_FLUSH);
  assign o_hazard_cnt = cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if ((o_stall || o_bubble || o_flush) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + HCNT_W'(1);
    end
  end

endmodule
